// File: rtl/leg_solver_pkg.sv
// Shared types and constants for the right-triangle leg solver.
package leg_solver_pkg;

  localparam int LEG_W       = 8;
  localparam int SQ_CYCLES   = 8;
  localparam int ROOT_CYCLES = 8;
  localparam int LATENCY     = SQ_CYCLES + SQ_CYCLES + 1 + ROOT_CYCLES;
  localparam int CNT_W       = 3;

  typedef enum logic [2:0] {
    IDLE,
    SQ_C,
    SQ_A,
    SUB,
    ROOT
  } state_t;

endpackage

// File: rtl/leg_solver_seq_squarer.sv
// Shift-add squarer, LSB first. load captures x and performs the first partial
// product at once, so a square is complete after load plus (W-1) steps.
module seq_squarer
  import leg_solver_pkg::*;
#(
  parameter int W = LEG_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   x,
  output logic [2*W-1:0] prod
);

  logic [2*W-1:0] mcand;
  logic [W-1:0]   mult;

  always_ff @(posedge clk) begin
    if (rst) begin
      prod  <= '0;
      mcand <= '0;
      mult  <= '0;
    end else if (load) begin
      prod  <= x[0] ? {{W{1'b0}}, x} : '0;
      mcand <= {{(W-1){1'b0}}, x, 1'b0};
      mult  <= x >> 1;
    end else if (step) begin
      if (mult[0]) prod <= prod + mcand;
      mcand <= mcand << 1;
      mult  <= mult >> 1;
    end
  end

endmodule

// File: rtl/leg_solver.sv
// Sequential leg solver: leg_out = floor(sqrt(c^2 - a^2)), err when a > c.
// Define LEG_SOLVER_ROUND_EN to round the result to nearest instead.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SQ_C  | squarer builds c^2 (load + 7 steps)
// SQ_A  | c^2 saved, squarer reused for a^2
// SUB   | radicand = c^2 - a^2, or 0 with err when a > c
// ROOT  | restoring square root, two radicand bits per cycle
module leg_solver
  import leg_solver_pkg::*;
#(
  parameter int WIDTH = LEG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] hyp_in,
  input  logic [WIDTH-1:0] leg_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] leg_out,
  output logic             err
);

  localparam int RW    = 2 * WIDTH;
  localparam int REM_W = 2 * WIDTH + 1;
  localparam logic [CNT_W-1:0] SQ_LAST   = CNT_W'(SQ_CYCLES - 1);
  localparam logic [CNT_W-1:0] ROOT_LAST = CNT_W'(ROOT_CYCLES - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   c_reg, a_reg;
  logic [RW-1:0]      c_sq, rad, sq_prod;
  logic [REM_W-1:0]   rem, rem_sh, trial, rem_new;
  logic [WIDTH-1:0]   root, root_new, leg_final;
  logic               err_next, ge, sq_load, sq_step;

  assign busy    = (state != IDLE);
  assign sq_load = ((state == SQ_C) || (state == SQ_A)) && (cnt == SQ_LAST);
  assign sq_step = ((state == SQ_C) || (state == SQ_A)) && (cnt != SQ_LAST);

  seq_squarer #(.W(WIDTH)) u_sq (
    .clk  (clk),
    .rst  (rst),
    .load (sq_load),
    .step (sq_step),
    .x    ((state == SQ_A) ? a_reg : c_reg),
    .prod (sq_prod)
  );

  always_comb begin
    rem_sh    = (rem << 2) | REM_W'(rad[RW-1 -: 2]);
    trial     = REM_W'({root, 2'b01});
    ge        = (rem_sh >= trial);
    rem_new   = ge ? (rem_sh - trial) : rem_sh;
    root_new  = {root[WIDTH-2:0], ge};
    leg_final = root_new;
`ifdef LEG_SOLVER_ROUND_EN
    // sqrt(x) >= r + 0.5 exactly when x - r^2 > r for integer x
    if (rem_new > REM_W'(root_new)) leg_final = root_new + WIDTH'(1);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      c_reg    <= '0;
      a_reg    <= '0;
      c_sq     <= '0;
      rad      <= '0;
      rem      <= '0;
      root     <= '0;
      err_next <= 1'b0;
      leg_out  <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          c_reg <= hyp_in;
          a_reg <= leg_in;
          c_sq  <= '0;
          rad   <= '0;
          rem   <= '0;
          root  <= '0;
          cnt   <= SQ_LAST;
          state <= SQ_C;
        end
        SQ_C: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            cnt   <= SQ_LAST;
            state <= SQ_A;
          end
        end
        SQ_A: begin
          // squarer still holds c^2 on the cycle it reloads with a
          if (cnt == SQ_LAST) c_sq <= sq_prod;
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= SUB;
        end
        SUB: begin
          if (sq_prod > c_sq) begin
            rad      <= '0;
            err_next <= 1'b1;
          end else begin
            rad      <= c_sq - sq_prod;
            err_next <= 1'b0;
          end
          cnt   <= ROOT_LAST;
          state <= ROOT;
        end
        ROOT: begin
          rad  <= rad << 2;
          rem  <= rem_new;
          root <= root_new;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            leg_out <= leg_final;
            err     <= err_next;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leg_solver.sv
// Self-checking bench for leg_solver against an arithmetic reference model.
`timescale 1ns/1ps
module tb_leg_solver;
  import leg_solver_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] hyp_in = '0;
  logic [7:0] leg_in = '0;
  logic       busy, done, err;
  logic [7:0] leg_out;

  int passed = 0;
  int total  = 0;

  leg_solver dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .hyp_in  (hyp_in),
    .leg_in  (leg_in),
    .busy    (busy),
    .done    (done),
    .leg_out (leg_out),
    .err     (err)
  );

  always #5 clk = ~clk;

  function automatic int ref_leg(input int c, input int a);
    int rad, b;
    rad = (a > c) ? 0 : c * c - a * a;
    b = 0;
    while ((b + 1) * (b + 1) <= rad) b++;
`ifdef LEG_SOLVER_ROUND_EN
    if (rad - b * b > b) b++;
`endif
    return b;
  endfunction

  task automatic start_op(input logic [7:0] c, input logic [7:0] a);
    @(negedge clk);
    hyp_in = c;
    leg_in = a;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    hyp_in = 8'($urandom);
    leg_in = 8'($urandom);
  endtask

  // Called one step after the accepting edge; returns edges until done (40 on timeout).
  task automatic wait_done(output int cycles, output int busy_cyc);
    cycles   = 0;
    busy_cyc = busy ? 1 : 0;
    while (cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      if (done) break;
      if (busy) busy_cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || leg_out !== 8'd0 || err !== 1'b0)
      $display("FAIL reset_outputs: busy=%b done=%b leg_out=%0d err=%b, required all 0",
               busy, done, leg_out, err);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed;
    int cv[6] = '{5, 255, 200, 10, 10, 13};
    int av[6] = '{3, 0, 200, 7, 6, 5};
    int ev[6] = '{4, 255, 0, 7, 8, 12};
    int cyc, bc;
    logic [7:0] held;
    for (int i = 0; i < 6; i++) begin
      start_op(8'(cv[i]), 8'(av[i]));
      wait_done(cyc, bc);
      total++;
      if (cyc !== LATENCY || busy !== 1'b0 || bc !== LATENCY)
        $display("FAIL dir_latency c=%0d a=%0d: done after %0d, busy cycles %0d, busy=%b; required %0d/%0d/0",
                 cv[i], av[i], cyc, bc, busy, LATENCY, LATENCY);
      else passed++;
      total++;
      if (leg_out !== 8'(ev[i]) || err !== 1'b0)
        $display("FAIL dir_result c=%0d a=%0d: leg_out=%0d err=%b, required %0d err=0",
                 cv[i], av[i], leg_out, err, ev[i]);
      else passed++;
      held = leg_out;
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || leg_out !== held)
        $display("FAIL dir_pulse c=%0d a=%0d: done=%b leg_out=%0d, required done=0 leg_out=%0d",
                 cv[i], av[i], done, leg_out, held);
      else passed++;
    end
  endtask

  task automatic test_err;
    int cyc, bc;
    start_op(8'd3, 8'd5);
    wait_done(cyc, bc);
    total++;
    if (cyc !== LATENCY || leg_out !== 8'd0 || err !== 1'b1)
      $display("FAIL err_set: cycles=%0d leg_out=%0d err=%b, required %0d/0/1",
               cyc, leg_out, err, LATENCY);
    else passed++;
    start_op(8'd13, 8'd5);
    wait_done(cyc, bc);
    total++;
    if (cyc !== LATENCY || leg_out !== 8'd12 || err !== 1'b0)
      $display("FAIL err_clear: cycles=%0d leg_out=%0d err=%b, required %0d/12/0",
               cyc, leg_out, err, LATENCY);
    else passed++;
  endtask

  task automatic test_random;
    int c, a, cyc, bc, exp_b;
    bit exp_e;
    for (int i = 0; i < 24; i++) begin
      c = int'($urandom_range(0, 255));
      a = (i % 4 == 3) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, c));
      exp_b = ref_leg(c, a);
      exp_e = (a > c);
      start_op(8'(c), 8'(a));
      wait_done(cyc, bc);
      total++;
      if (cyc !== LATENCY || leg_out !== 8'(exp_b) || err !== exp_e)
        $display("FAIL rand c=%0d a=%0d: cycles=%0d leg_out=%0d err=%b, required %0d/%0d/%0b",
                 c, a, cyc, leg_out, err, LATENCY, exp_b, exp_e);
      else passed++;
    end
  endtask

  task automatic test_busy_ignore;
    int cyc, extra;
    start_op(8'd13, 8'd5);
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 5) begin
        start = 1'b1; hyp_in = 8'd3; leg_in = 8'd5;
      end
      if (cyc == 6) start = 1'b0;
      if (done) break;
    end
    total++;
    if (cyc !== LATENCY || leg_out !== 8'd12 || err !== 1'b0)
      $display("FAIL busy_ignore: cycles=%0d leg_out=%0d err=%b, required %0d/12/0",
               cyc, leg_out, err, LATENCY);
    else passed++;
    extra = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    total++;
    if (extra !== 0)
      $display("FAIL busy_no_queue: %0d cycles of busy/done after finish, required 0", extra);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int cyc, bc;
    start_op(8'd10, 8'd6);
    wait_done(cyc, bc);
    total++;
    if (cyc !== LATENCY || leg_out !== 8'd8)
      $display("FAIL b2b_first: cycles=%0d leg_out=%0d, required %0d/8", cyc, leg_out, LATENCY);
    else passed++;
    start = 1'b1; hyp_in = 8'd255; leg_in = 8'd0;
    @(posedge clk); #1;
    start = 1'b0; hyp_in = 8'd1; leg_in = 8'd1;
    total++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL b2b_accept: busy=%b done=%b, required busy=1 done=0", busy, done);
    else passed++;
    wait_done(cyc, bc);
    total++;
    if (cyc !== LATENCY || bc !== LATENCY || leg_out !== 8'd255 || err !== 1'b0)
      $display("FAIL b2b_second: cycles=%0d busy=%0d leg_out=%0d err=%b, required %0d/%0d/255/0",
               cyc, bc, leg_out, err, LATENCY, LATENCY);
    else passed++;
  endtask

  task automatic test_mid_reset;
    int cyc, bc, seen;
    start_op(8'd100, 8'd60);
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || leg_out !== 8'd0 || err !== 1'b0)
      $display("FAIL midrst_outputs: busy=%b done=%b leg_out=%0d err=%b, required all 0",
               busy, done, leg_out, err);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    total++;
    if (seen !== 0)
      $display("FAIL midrst_abort: %0d cycles of busy/done after reset, required 0", seen);
    else passed++;
    start_op(8'd100, 8'd60);
    wait_done(cyc, bc);
    total++;
    if (cyc !== LATENCY || leg_out !== 8'(ref_leg(100, 60)) || err !== 1'b0)
      $display("FAIL midrst_fresh: cycles=%0d leg_out=%0d err=%b, required %0d/80/0",
               cyc, leg_out, err, LATENCY);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_err;
    test_random;
    test_busy_ignore;
    test_back_to_back;
    test_mid_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
